branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Execute-stage block directly downstream of the comparator unit. It consumes the comparator's registered-path compare result together with the decoded control-flow flags.
- Resolves BRANCH/JAL/JALR, computes the target and link value, and issues a redirect to fetch over a valid/ready handshake.
- Holds a multi-cycle flush to squash wrong-path instructions. Static predict-not-taken, so every taken control transfer is a redirect.

Parameters:
- XLEN, 32, datapath width (matches comparator).
- FLUSH_CYCLES, 2, cycles o_Flush stays asserted after redirect acceptance (0 allowed).
- CNT_WIDTH, 16, width of the saturating statistics counters.

Ports:
- i_Clock  input  1  system clock, rising edge.
- i_Reset_N  input  1  asynchronous active-low reset.
- i_Valid  input  1  upstream instruction valid.
- o_Ready  output  1  block can accept an instruction.
- i_Is_Branch  input  1  conditional branch.
- i_Is_Jal  input  1  JAL.
- i_Is_Jalr  input  1  JALR.
- i_Compare_Result  input  1  comparator output for this instruction.
- i_Pc  input  XLEN  instruction PC.
- i_Rs1  input  XLEN  rs1 value (JALR base).
- i_Imm  input  XLEN  sign-extended immediate.
- o_Redirect_Valid  output  1  redirect request to fetch.
- i_Redirect_Ready  input  1  fetch accepts redirect.
- o_Redirect_Pc  output  XLEN  redirect target.
- o_Flush  output  1  squash younger in-flight instructions.
- o_Link_Valid  output  1  one-cycle pulse: o_Link_Value to be written to rd.
- o_Link_Value  output  XLEN  i_Pc+4 of the accepted jump.
- o_Misaligned  output  1  one-cycle pulse: taken target not 4-byte aligned.
- o_Branch_Count  output  CNT_WIDTH  accepted conditional branches, saturating.
- o_Taken_Count  output  CNT_WIDTH  redirects issued, saturating.

Behaviour:
- Reset (async, i_Reset_N=0):
  - State goes to S_IDLE.
  - All registered outputs go to 0 immediately: o_Redirect_Valid, o_Redirect_Pc, o_Flush, o_Link_*, o_Misaligned, both counters.
  - Reset mid-redirect or mid-flush abandons the operation with no further pulses.
- Handshakes:
  - o_Ready = (state==S_IDLE); combinational.
  - Accept = i_Valid & o_Ready at a rising edge.
- Flag priority: i_Is_Jalr > i_Is_Jal > i_Is_Branch. An accepted instruction with no flag set has no effect.
- Target arithmetic (all sums modulo 2^XLEN, wrap silently):
  - JAL and BRANCH: i_Pc+i_Imm.
  - JALR: (i_Rs1+i_Imm) with bit 0 cleared.
- Taken = jalr | jal | (branch & i_Compare_Result).
- At accept:
  - JAL/JALR: o_Link_Valid=1 and o_Link_Value=i_Pc+4 in the next cycle, for one cycle. This happens even when misaligned.
  - BRANCH: o_Branch_Count increments, saturating at all-ones.
  - Taken and target[1:0]!=0: o_Misaligned pulses for one cycle next cycle. No redirect; state stays S_IDLE.
  - Taken and aligned: register o_Redirect_Pc=target, set o_Redirect_Valid=1 next cycle, go to S_REDIRECT.
  - Not-taken branch: stay in S_IDLE, no other output.
- S_REDIRECT:
  - o_Redirect_Valid and o_Redirect_Pc hold stable until i_Redirect_Ready=1 at an edge.
  - On that edge: o_Redirect_Valid drops next cycle and o_Taken_Count increments, saturating.
  - Then go to S_FLUSH with the counter loaded to FLUSH_CYCLES, or to S_IDLE if FLUSH_CYCLES==0.
- S_FLUSH:
  - o_Flush=1 for exactly FLUSH_CYCLES cycles, starting the cycle after redirect acceptance.
  - Then return to S_IDLE.
- Timing:
  - Latency accept→o_Redirect_Valid is 1 cycle.
  - Best-case taken-to-next-accept is 2+FLUSH_CYCLES cycles.
- i_Redirect_Ready while o_Redirect_Valid=0 is ignored.
- Input changes while o_Ready=0 are ignored.
- o_Redirect_Pc retains its last value after the handshake; it is don't-care when valid is low.

Test Plan:
- Reset then BEQ: i_Pc=0x100, i_Imm=0x20, i_Compare_Result=1, i_Redirect_Ready=1 → o_Redirect_Valid high 1 cycle later with 0x120. o_Flush high exactly 2 cycles after acceptance. o_Branch_Count=1, o_Taken_Count=1. o_Ready returns after flush.
- Not-taken branch: i_Compare_Result=0 → no redirect, o_Ready stays 1. Back-to-back accepts on consecutive cycles; o_Branch_Count increments each cycle.
- JALR: i_Rs1=0x1001, i_Imm=0x4, i_Pc=0x200 → o_Redirect_Pc=0x1004, o_Link_Value=0x204, o_Link_Valid one-cycle pulse.
- Backpressure: i_Redirect_Ready=0 for 5 cycles → o_Redirect_Valid/o_Redirect_Pc stable, o_Ready=0, no flush. Raising ready completes the handshake as normal.
- Misaligned JAL: i_Pc=0x100, i_Imm=0x2 → o_Misaligned pulses once, o_Link_Valid pulses, no redirect. Wrap case: JAL with i_Pc=0xFFFFFFFC, i_Imm=0x8 → target 0x4.
- Async reset asserted mid-S_REDIRECT and mid-S_FLUSH → outputs 0 immediately, o_Ready=1 after release. Separately, force 2^16 branches → o_Branch_Count saturates at 0xFFFF.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: resolves BRANCH/JAL/JALR, issues a redirect to fetch over
// valid/ready, produces the link value and holds a fixed-length flush after each redirect.
module branch_resolve_unit #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset_N,
  input  logic                 i_Valid,
  output logic                 o_Ready,
  input  logic                 i_Is_Branch,
  input  logic                 i_Is_Jal,
  input  logic                 i_Is_Jalr,
  input  logic                 i_Compare_Result,
  input  logic [XLEN-1:0]      i_Pc,
  input  logic [XLEN-1:0]      i_Rs1,
  input  logic [XLEN-1:0]      i_Imm,
  output logic                 o_Redirect_Valid,
  input  logic                 i_Redirect_Ready,
  output logic [XLEN-1:0]      o_Redirect_Pc,
  output logic                 o_Flush,
  output logic                 o_Link_Valid,
  output logic [XLEN-1:0]      o_Link_Value,
  output logic                 o_Misaligned,
  output logic [CNT_WIDTH-1:0] o_Branch_Count,
  output logic [CNT_WIDTH-1:0] o_Taken_Count
);

  localparam int unsigned FcW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [FcW-1:0] FlushLoad = FcW'(FLUSH_CYCLES);

  typedef enum logic [1:0] {StIdle, StRedirect, StFlush} state_e;

  state_e                state_q, state_d;
  logic [FcW-1:0]        flush_cnt_q, flush_cnt_d;
  logic                  redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]       redirect_pc_q, redirect_pc_d;
  logic                  link_valid_q, link_valid_d;
  logic [XLEN-1:0]       link_value_q, link_value_d;
  logic                  misaligned_q, misaligned_d;
  logic [CNT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0]  taken_cnt_q, taken_cnt_d;

  logic            accept;
  logic            do_jalr, do_jal, do_branch, taken, target_misaligned;
  logic [XLEN-1:0] target_sum, target;

  // Flag priority: JALR over JAL over BRANCH.
  assign do_jalr   = i_Is_Jalr;
  assign do_jal    = ~i_Is_Jalr & i_Is_Jal;
  assign do_branch = ~i_Is_Jalr & ~i_Is_Jal & i_Is_Branch;

  assign target_sum        = (do_jalr ? i_Rs1 : i_Pc) + i_Imm;
  assign target            = {target_sum[XLEN-1:1], target_sum[0] & ~do_jalr};
  assign taken             = do_jalr | do_jal | (do_branch & i_Compare_Result);
  assign target_misaligned = |target[1:0];

  assign o_Ready = (state_q == StIdle);
  assign accept  = i_Valid & o_Ready;

  always_comb begin
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    link_valid_d     = 1'b0;
    link_value_d     = link_value_q;
    misaligned_d     = 1'b0;
    branch_cnt_d     = branch_cnt_q;
    taken_cnt_d      = taken_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (do_jal || do_jalr) begin
            link_valid_d = 1'b1;
            link_value_d = i_Pc + XLEN'(4);
          end
          if (do_branch && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
          end
          if (taken) begin
            if (target_misaligned) begin
              misaligned_d = 1'b1;
            end else begin
              redirect_pc_d    = target;
              redirect_valid_d = 1'b1;
              state_d          = StRedirect;
            end
          end
        end
      end
      StRedirect: begin
        if (i_Redirect_Ready) begin
          redirect_valid_d = 1'b0;
          if (taken_cnt_q != '1) begin
            taken_cnt_d = taken_cnt_q + CNT_WIDTH'(1);
          end
          if (FLUSH_CYCLES == 0) begin
            state_d = StIdle;
          end else begin
            state_d     = StFlush;
            flush_cnt_d = FlushLoad;
          end
        end
      end
      StFlush: begin
        flush_cnt_d = flush_cnt_q - FcW'(1);
        if (flush_cnt_q == FcW'(1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      state_q          <= StIdle;
      flush_cnt_q      <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      link_valid_q     <= 1'b0;
      link_value_q     <= '0;
      misaligned_q     <= 1'b0;
      branch_cnt_q     <= '0;
      taken_cnt_q      <= '0;
    end else begin
      state_q          <= state_d;
      flush_cnt_q      <= flush_cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      link_valid_q     <= link_valid_d;
      link_value_q     <= link_value_d;
      misaligned_q     <= misaligned_d;
      branch_cnt_q     <= branch_cnt_d;
      taken_cnt_q      <= taken_cnt_d;
    end
  end

  assign o_Redirect_Valid = redirect_valid_q;
  assign o_Redirect_Pc    = redirect_pc_q;
  assign o_Flush          = (state_q == StFlush);
  assign o_Link_Valid     = link_valid_q;
  assign o_Link_Value     = link_value_q;
  assign o_Misaligned     = misaligned_q;
  assign o_Branch_Count   = branch_cnt_q;
  assign o_Taken_Count    = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed plus randomized bench for branch_resolve_unit against a behavioural model.
module tb_branch_resolve_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned FC   = 2;
  localparam int unsigned CW   = 16;
  localparam int          CntMax = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            valid = 1'b0;
  logic            is_branch = 1'b0, is_jal = 1'b0, is_jalr = 1'b0, cmp = 1'b0;
  logic            rr = 1'b0;
  logic [XLEN-1:0] pc = '0, rs1 = '0, imm = '0;
  logic            ready, rv, flush, lv, mis;
  logic [XLEN-1:0] rpc, lval;
  logic [CW-1:0]   bcnt, tcnt;

  int tests = 0;
  int failed = 0;
  int exp_br = 0;
  int exp_tk = 0;

  branch_resolve_unit #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
    .i_Clock(clk), .i_Reset_N(rst_n), .i_Valid(valid), .o_Ready(ready),
    .i_Is_Branch(is_branch), .i_Is_Jal(is_jal), .i_Is_Jalr(is_jalr),
    .i_Compare_Result(cmp), .i_Pc(pc), .i_Rs1(rs1), .i_Imm(imm),
    .o_Redirect_Valid(rv), .i_Redirect_Ready(rr), .o_Redirect_Pc(rpc), .o_Flush(flush),
    .o_Link_Valid(lv), .o_Link_Value(lval), .o_Misaligned(mis),
    .o_Branch_Count(bcnt), .o_Taken_Count(tcnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit jr, input bit j, input bit b, input bit c,
                       input logic [XLEN-1:0] p, input logic [XLEN-1:0] r,
                       input logic [XLEN-1:0] i);
    valid = 1'b1; is_jalr = jr; is_jal = j; is_branch = b; cmp = c;
    pc = p; rs1 = r; imm = i;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_bcnt"}, 64'(bcnt), 64'(exp_br));
    chk({tag, "_tcnt"}, 64'(tcnt), 64'(exp_tk));
  endtask

  function automatic int sat_inc(input int v);
    return (v < CntMax) ? v + 1 : v;
  endfunction

  // Reference: what one accepted instruction should produce, straight from the ISA rules.
  function automatic void predict(input bit jr, input bit j, input bit b, input bit c,
                                  input logic [XLEN-1:0] p, input logic [XLEN-1:0] r,
                                  input logic [XLEN-1:0] i,
                                  output bit link, output bit redirect, output bit misal,
                                  output logic [XLEN-1:0] tgt, output bit counted_br);
    bit tk;
    longint unsigned sum;
    link = 0; redirect = 0; misal = 0; tgt = '0; counted_br = 0; tk = 0;
    if (jr) begin
      link = 1; tk = 1;
      sum = (longint'(r) + longint'(i)) % 64'h1_0000_0000;
      sum = sum - (sum % 2);
    end else if (j) begin
      link = 1; tk = 1;
      sum = (longint'(p) + longint'(i)) % 64'h1_0000_0000;
    end else if (b) begin
      counted_br = 1; tk = c;
      sum = (longint'(p) + longint'(i)) % 64'h1_0000_0000;
    end else begin
      sum = 0;
    end
    tgt = XLEN'(sum);
    if (tk) begin
      misal    = (sum % 4) != 0;
      redirect = !misal;
    end
  endfunction

  // From a cycle where the redirect is already visible: hold, handshake, flush, back to idle.
  task automatic finish_redirect(input string tag, input logic [XLEN-1:0] tgt, input int hold);
    for (int k = 0; k < hold; k++) begin
      rr = 1'b0;
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom, $urandom, $urandom);
      step();
      chk({tag, "_hold_rv"}, 64'(rv), 1);
      chk({tag, "_hold_rpc"}, 64'(rpc), 64'(tgt));
      chk({tag, "_hold_ready"}, 64'(ready), 0);
      chk({tag, "_hold_flush"}, 64'(flush), 0);
    end
    rr = 1'b1;
    step();
    rr = 1'b0;
    exp_tk = sat_inc(exp_tk);
    chk({tag, "_hs_rv"}, 64'(rv), 0);
    chk({tag, "_hs_flush"}, 64'(flush), 64'(FC > 0));
    chk({tag, "_hs_lv"}, 64'(lv), 0);
    chk({tag, "_hs_tcnt"}, 64'(tcnt), 64'(exp_tk));
    for (int k = 1; k <= int'(FC); k++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom, $urandom, $urandom);
      rr = 1'($urandom_range(0, 1));
      step();
      chk({tag, "_fl_flush"}, 64'(flush), 64'(k < int'(FC)));
      chk({tag, "_fl_ready"}, 64'(ready), 64'(k == int'(FC)));
      chk({tag, "_fl_rv"}, 64'(rv), 0);
    end
    valid = 1'b0;
    rr = 1'b0;
  endtask

  initial begin
    bit link, redirect, misal, counted_br;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] p, r, i;
    bit jr, j, b, c;

    // Reset state
    #12;
    chk("rst_ready", 64'(ready), 1);
    chk("rst_rv", 64'(rv), 0);
    chk("rst_rpc", 64'(rpc), 0);
    chk("rst_flush", 64'(flush), 0);
    chk("rst_lv", 64'(lv), 0);
    chk("rst_lval", 64'(lval), 0);
    chk("rst_mis", 64'(mis), 0);
    chk_counts("rst");
    rst_n = 1'b1;
    step();

    // Taken BEQ
    drive(0, 0, 1, 1, 32'h100, 32'h0, 32'h20);
    rr = 1'b1;
    step();
    valid = 1'b0;
    exp_br = sat_inc(exp_br);
    chk("beq_rv", 64'(rv), 1);
    chk("beq_rpc", 64'(rpc), 64'h120);
    chk("beq_ready", 64'(ready), 0);
    chk("beq_flush", 64'(flush), 0);
    chk("beq_lv", 64'(lv), 0);
    finish_redirect("beq", 32'h120, 0);
    chk_counts("beq");

    // Back-to-back not-taken branches
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 0, 32'h400 + 32'(4 * k), 32'h0, 32'h40);
      step();
      exp_br = sat_inc(exp_br);
      chk("nt_bcnt", 64'(bcnt), 64'(exp_br));
      chk("nt_ready", 64'(ready), 1);
      chk("nt_rv", 64'(rv), 0);
    end
    valid = 1'b0;

    // JALR clears bit 0 of the target
    drive(1, 0, 0, 0, 32'h200, 32'h1001, 32'h4);
    step();
    valid = 1'b0;
    chk("jalr_rv", 64'(rv), 1);
    chk("jalr_rpc", 64'(rpc), 64'h1004);
    chk("jalr_lv", 64'(lv), 1);
    chk("jalr_lval", 64'(lval), 64'h204);
    finish_redirect("jalr", 32'h1004, 0);
    chk_counts("jalr");

    // Backpressure for 5 cycles
    drive(0, 1, 0, 0, 32'h300, 32'h0, 32'h40);
    step();
    valid = 1'b0;
    chk("bp_rv", 64'(rv), 1);
    finish_redirect("bp", 32'h340, 5);
    chk_counts("bp");

    // Misaligned JAL: link still written, no redirect
    drive(0, 1, 0, 0, 32'h100, 32'h0, 32'h2);
    step();
    valid = 1'b0;
    chk("mis_mis", 64'(mis), 1);
    chk("mis_lv", 64'(lv), 1);
    chk("mis_lval", 64'(lval), 64'h104);
    chk("mis_rv", 64'(rv), 0);
    chk("mis_ready", 64'(ready), 1);
    step();
    chk("mis_pulse_end", 64'(mis), 0);
    chk("mis_lv_end", 64'(lv), 0);
    chk_counts("mis");

    // Wrapping JAL target
    drive(0, 1, 0, 0, 32'hFFFF_FFFC, 32'h0, 32'h8);
    step();
    valid = 1'b0;
    chk("wrap_rpc", 64'(rpc), 64'h4);
    chk("wrap_lval", 64'(lval), 64'h0);
    finish_redirect("wrap", 32'h4, 1);

    // Randomized instructions against the model
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 2)) begin
        valid = 1'b0;
        step();
        chk("rnd_idle_ready", 64'(ready), 1);
      end
      jr = 1'($urandom_range(0, 3) == 0);
      j  = 1'($urandom_range(0, 2) == 0);
      b  = 1'($urandom_range(0, 1));
      c  = 1'($urandom_range(0, 1));
      p  = $urandom & ~32'h3;
      r  = $urandom;
      i  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : (32'($urandom) & ~32'h3);
      predict(jr, j, b, c, p, r, i, link, redirect, misal, tgt, counted_br);
      drive(jr, j, b, c, p, r, i);
      step();
      valid = 1'b0;
      if (counted_br) exp_br = sat_inc(exp_br);
      chk("rnd_lv", 64'(lv), 64'(link));
      if (link) chk("rnd_lval", 64'(lval), 64'(p + 32'd4));
      chk("rnd_mis", 64'(mis), 64'(misal));
      chk("rnd_rv", 64'(rv), 64'(redirect));
      chk("rnd_ready", 64'(ready), 64'(!redirect));
      if (redirect) begin
        chk("rnd_rpc", 64'(rpc), 64'(tgt));
        finish_redirect("rnd", tgt, $urandom_range(0, 3));
      end
      chk_counts("rnd");
    end

    // Async reset while a redirect is pending
    drive(0, 1, 0, 0, 32'h400, 32'h0, 32'h10);
    step();
    valid = 1'b0;
    chk("rr_pre_rv", 64'(rv), 1);
    #2 rst_n = 1'b0;
    #1;
    exp_br = 0;
    exp_tk = 0;
    chk("rr_rv", 64'(rv), 0);
    chk("rr_rpc", 64'(rpc), 0);
    chk("rr_lv", 64'(lv), 0);
    chk("rr_lval", 64'(lval), 0);
    chk("rr_ready", 64'(ready), 1);
    chk_counts("rr");
    #2 rst_n = 1'b1;
    step();
    chk("rr_post_rv", 64'(rv), 0);
    chk("rr_post_flush", 64'(flush), 0);
    chk("rr_post_ready", 64'(ready), 1);

    // Async reset during the flush
    drive(0, 0, 1, 1, 32'h800, 32'h0, 32'h100);
    rr = 1'b1;
    step();
    valid = 1'b0;
    step();
    rr = 1'b0;
    chk("rf_pre_flush", 64'(flush), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rf_flush", 64'(flush), 0);
    chk("rf_rv", 64'(rv), 0);
    chk("rf_ready", 64'(ready), 1);
    chk_counts("rf");
    #2 rst_n = 1'b1;
    step();
    chk("rf_post_flush", 64'(flush), 0);
    chk("rf_post_ready", 64'(ready), 1);

    // Branch counter saturation
    drive(0, 0, 1, 0, 32'h1000, 32'h0, 32'h8);
    for (int k = 0; k < 65540; k++) begin
      step();
      exp_br = sat_inc(exp_br);
    end
    valid = 1'b0;
    chk("sat_bcnt", 64'(bcnt), 64'hFFFF);
    chk_counts("sat");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
